// File: rtl/gate_sweep_if.sv
// Handshake and result bundle for gate_sweep.
// GATE_SWEEP_SIGNATURE_EN adds the sig_o signature output.
interface gate_sweep_if #(
    parameter int unsigned WIDTH = 2
);
    logic             start;
    logic             abort;
    logic [2:0]       op;
    logic [WIDTH-1:0] vec_o;
    logic             out_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH:0]   ones_o;
`ifdef GATE_SWEEP_SIGNATURE_EN
    logic [15:0]      sig_o;

    modport master (
        output start, abort, op,
        input  vec_o, out_o, valid_o, busy_o, done_o, ones_o, sig_o
    );
    modport slave (
        input  start, abort, op,
        output vec_o, out_o, valid_o, busy_o, done_o, ones_o, sig_o
    );
`else
    modport master (
        output start, abort, op,
        input  vec_o, out_o, valid_o, busy_o, done_o, ones_o
    );
    modport slave (
        input  start, abort, op,
        output vec_o, out_o, valid_o, busy_o, done_o, ones_o
    );
`endif
endinterface

// File: rtl/gate_sweep.sv
// Truth-table sweep of a selectable gate over all 2^WIDTH input vectors.
// GATE_SWEEP_SIGNATURE_EN adds a 16-bit rotating signature of the results.
module gate_sweep #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned STEP_CYCLES = 10
) (
    input logic        clk,
    input logic        rst_n,
    gate_sweep_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0]       LAST_STEP = 8'(STEP_CYCLES - 1);
    localparam logic [WIDTH-1:0] LAST_VEC  = '1;

    logic [1:0]       state;
    logic [7:0]       hold_cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] vec;
    logic             out;
    logic             valid;
    logic             done;
    logic [WIDTH:0]   ones;
    logic             last_hold;

    assign last_hold = (state == HOLD) && (hold_cnt == LAST_STEP);

    always_comb begin
        out = &vec;
        case (op_q)
            3'd1:    out = |vec;
            3'd2:    out = ^vec;
            3'd3:    out = ~&vec;
            3'd4:    out = ~|vec;
            3'd5:    out = ~^vec;
            default: out = &vec;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            op_q     <= '0;
            vec      <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            ones     <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        ones     <= '0;
                        done     <= 1'b0;
                        vec      <= '0;
                        hold_cnt <= '0;
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // abort outranks the last-cycle tally so ones stays at its partial value
                    if (bus.abort) begin
                        state    <= IDLE;
                        vec      <= '0;
                        hold_cnt <= '0;
                    end else if (hold_cnt == LAST_STEP) begin
                        hold_cnt <= '0;
                        if (out) ones <= ones + (WIDTH+1)'(1);
                        if (vec == LAST_VEC) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            vec   <= vec + WIDTH'(1);
                            valid <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_SWEEP_SIGNATURE_EN
    logic [15:0] sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (state == IDLE && bus.start) begin
            sig <= '0;
        end else if (last_hold && !bus.abort) begin
            sig <= {sig[14:0], sig[15]} ^ {15'b0, out};
        end
    end

    assign bus.sig_o = sig;
`endif

    assign bus.vec_o   = vec;
    assign bus.out_o   = out;
    assign bus.valid_o = valid;
    assign bus.busy_o  = (state != IDLE);
    assign bus.done_o  = done;
    assign bus.ones_o  = ones;
endmodule

// File: tb/tb_gate_sweep.sv
// Directed self-checking bench for gate_sweep (WIDTH=2/STEP=10 and WIDTH=3/STEP=1 instances).
module tb_gate_sweep;
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    gate_sweep_if #(.WIDTH(2)) bus2 ();
    gate_sweep_if #(.WIDTH(3)) bus3 ();

    gate_sweep #(.WIDTH(2), .STEP_CYCLES(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    gate_sweep #(.WIDTH(3), .STEP_CYCLES(1)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mask bit i is the expected gate output for vector i
    task automatic run2(input logic [2:0] sop, input logic [3:0] mask, input logic [2:0] exp_ones,
                        input bit abort_with_start, input bit disturb);
        bus2.op    = sop;
        bus2.start = 1'b1;
        bus2.abort = abort_with_start;
        tick();
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 10; c++) begin
                if (c == 0) begin
                    check($sformatf("op%0d vec[%0d]", sop, i), bus2.vec_o, i);
                    check($sformatf("op%0d out[%0d]", sop, i), bus2.out_o, mask[i]);
                end
                check($sformatf("op%0d valid[%0d.%0d]", sop, i, c), bus2.valid_o, (c == 0));
                check($sformatf("op%0d busy[%0d.%0d]", sop, i, c), bus2.busy_o, 1);
                check($sformatf("op%0d done[%0d.%0d]", sop, i, c), bus2.done_o, 0);
                if (disturb && i == 1 && c == 5) begin
                    bus2.start = 1'b1;
                    bus2.op    = sop ^ 3'd1;
                end else begin
                    bus2.start = 1'b0;
                end
                tick();
            end
        end
        check($sformatf("op%0d done_in_DONE", sop), bus2.done_o, 1);
        check($sformatf("op%0d busy_in_DONE", sop), bus2.busy_o, 1);
        check($sformatf("op%0d valid_in_DONE", sop), bus2.valid_o, 0);
        check($sformatf("op%0d ones", sop), bus2.ones_o, exp_ones);
        bus2.abort = 1'b1;
        tick();
        bus2.abort = 1'b0;
        check($sformatf("op%0d busy_idle", sop), bus2.busy_o, 0);
        check($sformatf("op%0d done_sticky", sop), bus2.done_o, 1);
        check($sformatf("op%0d ones_hold", sop), bus2.ones_o, exp_ones);
        bus2.op = 3'd0;
        tick();
    endtask

    task automatic run3(input logic [2:0] sop, input logic [7:0] mask, input logic [3:0] exp_ones);
        bus3.op    = sop;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("w3 op%0d vec[%0d]", sop, i), bus3.vec_o, i);
            check($sformatf("w3 op%0d out[%0d]", sop, i), bus3.out_o, mask[i]);
            check($sformatf("w3 op%0d valid[%0d]", sop, i), bus3.valid_o, 1);
            check($sformatf("w3 op%0d done[%0d]", sop, i), bus3.done_o, 0);
            tick();
        end
        check($sformatf("w3 op%0d done", sop), bus3.done_o, 1);
        check($sformatf("w3 op%0d ones", sop), bus3.ones_o, exp_ones);
        tick();
        check($sformatf("w3 op%0d busy_idle", sop), bus3.busy_o, 0);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        bus2.op    = 3'd0;
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
        bus3.op    = 3'd0;
        repeat (2) tick();
        check("rst vec", bus2.vec_o, 0);
        check("rst out", bus2.out_o, 0);
        check("rst valid", bus2.valid_o, 0);
        check("rst busy", bus2.busy_o, 0);
        check("rst done", bus2.done_o, 0);
        check("rst ones", bus2.ones_o, 0);
        check("rst w3 busy", bus3.busy_o, 0);
        rst_n = 1'b1;
        tick();

        run2(3'd0, 4'b1000, 3'd1, 1'b0, 1'b0);
`ifdef GATE_SWEEP_SIGNATURE_EN
        check("sig AND", bus2.sig_o, 16'h0001);
`endif
        run2(3'd1, 4'b1110, 3'd3, 1'b0, 1'b0);
        run2(3'd3, 4'b0111, 3'd3, 1'b1, 1'b0);
        run2(3'd5, 4'b1001, 3'd2, 1'b0, 1'b1);
        run2(3'd2, 4'b0110, 3'd2, 1'b0, 1'b0);
        run2(3'd4, 4'b0001, 3'd1, 1'b0, 1'b0);

        // abort at vector 2 of a NOR sweep: vector 0 already counted
        bus2.op    = 3'd4;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (20) tick();
        check("abort pre vec", bus2.vec_o, 2);
        bus2.abort = 1'b1;
        tick();
        bus2.abort = 1'b0;
        check("abort busy", bus2.busy_o, 0);
        check("abort done", bus2.done_o, 0);
        check("abort vec", bus2.vec_o, 0);
        check("abort ones", bus2.ones_o, 1);
        check("abort valid", bus2.valid_o, 0);
        repeat (5) tick();
        check("abort idle busy", bus2.busy_o, 0);
        check("abort idle ones", bus2.ones_o, 1);
        check("abort idle vec", bus2.vec_o, 0);

        // asynchronous reset mid-sweep (NOR, vector 1, ones=1)
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (15) tick();
        check("pre-rst vec", bus2.vec_o, 1);
        check("pre-rst ones", bus2.ones_o, 1);
        rst_n = 1'b0;
        #2;
        check("async rst vec", bus2.vec_o, 0);
        check("async rst busy", bus2.busy_o, 0);
        check("async rst ones", bus2.ones_o, 0);
        check("async rst done", bus2.done_o, 0);
        check("async rst valid", bus2.valid_o, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post-rst busy", bus2.busy_o, 0);
        check("post-rst vec", bus2.vec_o, 0);
        check("post-rst ones", bus2.ones_o, 0);
        check("post-rst done", bus2.done_o, 0);
        run2(3'd1, 4'b1110, 3'd3, 1'b0, 1'b0);

        run3(3'd2, 8'b1001_0110, 4'd4);
        run3(3'd7, 8'b1000_0000, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
